seq_divider: RTL

//   Sequential unsigned restoring divider: one quotient bit per clock, start/done handshake.

---
 rtl/seq_divider.sv | 106 ++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock with a
// start/done handshake. Divide-by-zero short-circuits straight to DONE.
module seq_divider #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] r;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   r_sub;
    logic             ge;
    logic [WIDTH-1:0] r_nx;
    logic [WIDTH-1:0] q_nx;

    // One restoring step: shift the next dividend bit into the partial
    // remainder, subtract when it fits, and shift the outcome into q.
    always_comb begin
        r_sh  = {r, q[WIDTH-1]};
        r_sub = r_sh - {1'b0, d};
        ge    = (r_sh >= {1'b0, d});
        r_nx  = ge ? r_sub[WIDTH-1:0] : r_sh[WIDTH-1:0];
        q_nx  = {q[WIDTH-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            q           <= '0;
            d           <= '0;
            r           <= '0;
            cnt         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            busy        <= 1'b0;
                            state       <= DONE;
                        end else begin
                            q     <= dividend;
                            d     <= divisor;
                            r     <= '0;
                            cnt   <= CW'(WIDTH - 1);
                            busy  <= 1'b1;
                            state <= RUN;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    q <= q_nx;
                    r <= r_nx;
                    if (cnt == '0) begin
                        quotient  <= q_nx;
                        remainder <= r_nx;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
